multiplicador_controle_shift_add: RTL and testbench

- Sequential control and datapath stage of the shift-add multiplier. It sits directly around the combinational Adder.
- Drives Adder's OperandoA/OperandoB each step and consumes its (N+1)-bit Soma.
- Accumulates partial products into a 2N-bit register and shifts right once per step.
- After N steps it presents the unsigned product with a one-cycle done pulse.

---
 rtl/multiplicador_controle_shift_add.sv | 153 +++++++++++++++
 tb/tb_multiplicador_controle_shift_add.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_controle_shift_add.sv
// ---------------------------------------------------------------------------
// multiplicador_controle_shift_add
//
// Sequential control and datapath of an unsigned shift-add multiplier.
// The combinational adder lives outside this module. Each step, this block
// presents the upper accumulator half and the (possibly masked) multiplicand
// to the adder. It then takes the (N+1)-bit sum back, so the carry is never
// lost, and shifts the whole accumulator right by one.
//
// Optional feature (macro ATALHO_ZERO_EN):
//   When the macro is defined, a start with a zero operand jumps straight to
//   FIM and loads 0 into the product. Pronto then rises one cycle later and
//   Ocupado never asserts. When the macro is undefined, zero operands take
//   the full N steps.
//
// Parameters:
//   N                 operand width in bits (N >= 2)
//
// Ports:
//   i_clock           system clock, rising-edge active
//   i_reset_n         asynchronous active-low reset
//   i_iniciar         start request, sampled only in OCIOSO
//   i_multiplicando   operand M, captured on an accepted start
//   i_multiplicador   operand Q, captured on an accepted start
//   i_soma            adder result (o_operando_a + o_operando_b), N+1 bits
//   o_operando_a      to adder: upper half of the accumulator
//   o_operando_b      to adder: M when the current Q LSB is 1, else 0
//   o_produto         final 2N-bit product, registered, held until the next
//                     completion or reset
//   o_pronto          one-cycle pulse, o_produto newly valid
//   o_ocupado         high while a multiplication is in progress
// ---------------------------------------------------------------------------
module multiplicador_controle_shift_add #(
  parameter int N = 4
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic           i_iniciar,
  input  logic [N-1:0]   i_multiplicando,
  input  logic [N-1:0]   i_multiplicador,
  input  logic [N:0]     i_soma,
  output logic [N-1:0]   o_operando_a,
  output logic [N-1:0]   o_operando_b,
  output logic [2*N-1:0] o_produto,
  output logic           o_pronto,
  output logic           o_ocupado
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_ULTIMO = CW'(N - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    PASSO  = 2'd1,
    FIM    = 2'd2
  } estado_t;

  estado_t          r_estado;
  estado_t          w_estado_next;
  logic [N-1:0]     r_mreg;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;
  logic [CW-1:0]    r_cont;
  logic [2*N-1:0]   r_produto;
  logic [2*N-1:0]   w_deslocado;
  logic             w_aceita;
  logic             w_zero;
  logic             w_ultimo;

  // Accumulator after this step's add and shift: {Soma, Lo} >> 1.
  // Soma[N:1] becomes Hi and Soma[0] enters Lo at its MSB.
  assign w_deslocado = {i_soma, r_lo[N-1:1]};
  assign w_ultimo    = (r_cont == C_ULTIMO);

`ifdef ATALHO_ZERO_EN
  assign w_zero = (i_multiplicando == '0) || (i_multiplicador == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign o_operando_a = r_hi;
  assign o_operando_b = r_lo[0] ? r_mreg : '0;
  assign o_produto    = r_produto;

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_estado_next;
    end
  end

  // Next state and status outputs. The status outputs are decoded from the
  // registered state only, so they are glitch-free and read 0 during reset.
  always_comb begin
    w_estado_next = r_estado;
    w_aceita      = 1'b0;
    o_pronto      = 1'b0;
    o_ocupado     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (i_iniciar) begin
          w_aceita      = 1'b1;
          w_estado_next = w_zero ? FIM : PASSO;
        end
      end
      PASSO: begin
        o_ocupado = 1'b1;
        if (w_ultimo) begin
          w_estado_next = FIM;
        end
      end
      FIM: begin
        o_pronto      = 1'b1;
        w_estado_next = OCIOSO;
      end
      default: begin
        w_estado_next = OCIOSO;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mreg    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cont    <= '0;
      r_produto <= '0;
    end else begin
      if (w_aceita) begin
        r_mreg <= i_multiplicando;
        r_hi   <= '0;
        r_lo   <= i_multiplicador;
        r_cont <= '0;
        if (w_zero) begin
          r_produto <= '0;
        end
      end else if (r_estado == PASSO) begin
        r_hi   <= i_soma[N:1];
        r_lo   <= {i_soma[0], r_lo[N-1:1]};
        r_cont <= r_cont + CW'(1);
        // On the Nth step, the shifted accumulator is the finished product.
        if (w_ultimo) begin
          r_produto <= w_deslocado;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiplicador_controle_shift_add.sv
module tb_multiplicador_controle_shift_add;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic           iniciar;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [N:0]     soma;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [2*N-1:0] produto;
  logic           pronto;
  logic           ocupado;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic carry_seen = 1'b0;

  // Adder model for the external combinational stage
  assign soma = {1'b0, op_a} + {1'b0, op_b};

  multiplicador_controle_shift_add #(.N(N)) dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_iniciar       (iniciar),
    .i_multiplicando (mcand),
    .i_multiplicador (mplier),
    .i_soma          (soma),
    .o_operando_a    (op_a),
    .o_operando_b    (op_b),
    .o_produto       (produto),
    .o_pronto        (pronto),
    .o_ocupado       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record whether the adder carry bit is ever set while the multiplier is stepping.
  always @(negedge clk) if (ocupado && soma[N]) carry_seen <= 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands with Iniciar high. Return at the negedge after the accepting edge.
  task automatic start_op(input logic [N-1:0] m, input logic [N-1:0] q, input logic hold);
    @(negedge clk);
    mcand   = m;
    mplier  = q;
    iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) iniciar = 1'b0;
  endtask

  // Count negedges until Pronto is seen, bounded.
  // Also count the Ocupado cycles seen on the way.
  task automatic wait_pronto(output int j, output int ocup);
    j    = 0;
    ocup = 0;
    while (!pronto && j < 30) begin
      if (ocupado) ocup++;
      @(negedge clk);
      j++;
    end
  endtask

  int j, ocup, t1, t2, pulses;

  initial begin
    rst_n   = 1'b0;
    iniciar = 1'b0;
    mcand   = '0;
    mplier  = '0;

    // Reset
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_produto", 32'(produto), 0);
    check("rst_pronto",  32'(pronto),  0);
    check("rst_ocupado", 32'(ocupado), 0);
    check("rst_op_a",    32'(op_a),    0);
    check("rst_op_b",    32'(op_b),    0);

    // 1 x 1
    start_op(4'd1, 4'd1, 1'b0);
    check("1x1_op_a_step0", 32'(op_a), 0);
    check("1x1_op_b_step0", 32'(op_b), 1);
    wait_pronto(j, ocup);
    check("1x1_latency", 32'(j),    4);
    check("1x1_ocupado", 32'(ocup), 4);
    check("1x1_produto", 32'(produto), 1);
    check("1x1_ocup_fim", 32'(ocupado), 0);
    $display("op M=1 Q=1 produto=%0d lat=%0d", produto, j);
    @(negedge clk);
    check("1x1_pronto_pulse", 32'(pronto), 0);
    check("1x1_produto_hold", 32'(produto), 1);

    // Back-to-back: 5 x 10, then 8 x 8, with Iniciar held high
    start_op(4'd5, 4'd10, 1'b1);
    check("5x10_op_b_step0", 32'(op_b), 0);
    mcand  = 4'd8;
    mplier = 4'd8;
    wait_pronto(j, ocup);
    t1 = cyc;
    check("5x10_latency", 32'(j), 4);
    check("5x10_produto", 32'(produto), 50);
    $display("op M=5 Q=10 produto=%0d lat=%0d", produto, j);
    @(negedge clk);
    check("b2b_pronto_low", 32'(pronto), 0);
    wait_pronto(j, ocup);
    t2 = cyc;
    iniciar = 1'b0;
    check("8x8_produto", 32'(produto), 64);
    check("b2b_spacing", 32'(t2 - t1), 6);
    $display("op M=8 Q=8 produto=%0d spacing=%0d", produto, t2 - t1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", 32'(ocupado), 0);

    // Zero operand
    start_op(4'd0, 4'd3, 1'b0);
    wait_pronto(j, ocup);
`ifdef ATALHO_ZERO_EN
    check("0x3_latency", 32'(j),    0);
    check("0x3_ocupado", 32'(ocup), 0);
`else
    check("0x3_latency", 32'(j),    4);
    check("0x3_ocupado", 32'(ocup), 4);
`endif
    check("0x3_produto", 32'(produto), 0);
    $display("op M=0 Q=3 produto=%0d lat=%0d", produto, j);
    @(negedge clk);

    // 15 x 15: full range, carry out of the adder must be kept
    carry_seen = 1'b0;
    start_op(4'd15, 4'd15, 1'b0);
    wait_pronto(j, ocup);
    check("15x15_latency", 32'(j), 4);
    check("15x15_produto", 32'(produto), 225);
    check("15x15_carry",   32'(carry_seen), 1);
    $display("op M=15 Q=15 produto=%0d lat=%0d", produto, j);
    @(negedge clk);

    // Reset in the middle of an operation, with a second start ignored
    start_op(4'd7, 4'd9, 1'b0);
    @(negedge clk);
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    check("abort_still_busy", 32'(ocupado), 1);
    rst_n = 1'b0;
    #1;
    check("abort_rst_ocupado", 32'(ocupado), 0);
    check("abort_rst_produto", 32'(produto), 0);
    check("abort_rst_op_a",    32'(op_a),    0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pronto) pulses++;
    end
    check("abort_no_pronto", 32'(pulses), 0);
    check("abort_produto",   32'(produto), 0);
    $display("op M=7 Q=9 aborted produto=%0d pulses=%0d", produto, pulses);

    // Fresh start after the abort
    start_op(4'd7, 4'd9, 1'b0);
    wait_pronto(j, ocup);
    check("7x9_latency", 32'(j), 4);
    check("7x9_produto", 32'(produto), 63);
    $display("op M=7 Q=9 produto=%0d lat=%0d", produto, j);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
